// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, key-schedule word helpers,
// state/word typedefs and the core FSM encoding.
package aes_pkg;

  // Byte 0 of the block sits in element [15] (bits 127:120), column-major.
  typedef logic [15:0][7:0] aes_state_t;
  typedef logic [31:0]      aes_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_t;

  // Forward S-box, indexed directly by the input byte value.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [7:0] b);
    return x2(b) ^ b;
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for key-schedule word index i/NK (1-based).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped when last) -> AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  aes_state_t state_in,
  input  aes_state_t rkey,
  input  logic       last,
  output aes_state_t state_out
);

  // Byte n of the block lives at row n%4, column n/4, i.e. element [15-n].
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // SubBytes fused with ShiftRows: row r rotates left by r columns.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r + 4*c] = SBOX[state_in[15 - (r + 4*((c + r) % 4))]];
      end
    end
  end

  // MixColumns on each column independently.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c]     = x2(sr[4*c]) ^ x3(sr[4*c+1]) ^ sr[4*c+2]     ^ sr[4*c+3];
      mc[4*c + 1] = sr[4*c]     ^ x2(sr[4*c+1]) ^ x3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c + 2] = sr[4*c]     ^ sr[4*c+1]     ^ x2(sr[4*c+2]) ^ x3(sr[4*c+3]);
      mc[4*c + 3] = x3(sr[4*c]) ^ sr[4*c+1]     ^ sr[4*c+2]     ^ x2(sr[4*c+3]);
    end
  end

  // AddRoundKey, with the MixColumns bypass for the final round.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      state_out[15 - n] = (last ? sr[n] : mc[n]) ^ rkey[15 - n];
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryption core: one round per clock, round keys
// expanded on the fly from a sliding window of the last NK schedule words.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid and its payload stay stable until that edge, and ready
// never depends combinationally on valid (both ready/valid are registered).
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                eph1,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                busy,
  output logic [3:0]          round_idx
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end

  aes_fsm_t   fsm;
  aes_state_t st;
  aes_word_t  win [NK];   // w[wcnt-NK .. wcnt-1]
  logic [6:0] wcnt;       // index of the next schedule word to generate

  aes_word_t  ext [NK+4]; // window followed by w[wcnt .. wcnt+3]
  logic [6:0] need;
  logic       gen;
  logic       last_round;
  aes_state_t rkey;
  aes_state_t rnd_out;

  // Generate the next four schedule words after the window.
  always_comb begin : p_ext
    int wi;
    wi = 0;
    for (int k = 0; k < NK; k++) ext[k] = win[k];
    for (int k = 0; k < 4; k++) begin
      wi = int'(wcnt) + k;
      if (wi % NK == 0)
        ext[NK+k] = ext[k] ^ sub_word(rot_word(ext[NK+k-1])) ^ {rcon(4'(wi / NK)), 24'h0};
      else if (NK == 8 && wi % NK == 4)
        ext[NK+k] = ext[k] ^ sub_word(ext[NK+k-1]);
      else
        ext[NK+k] = ext[k] ^ ext[NK+k-1];
    end
  end

  // Select round key w[4r..4r+3]; the window only advances when words up to
  // 4r+3 are not yet generated, which keeps >= 4 unconsumed words for NK=6.
  always_comb begin : p_rkey
    int ro;
    ro   = 4 * int'(round_idx) - int'(wcnt) + NK;
    rkey = '0;
    for (int j = 0; j <= NK; j++) begin
      if (j == ro) rkey = {ext[j], ext[j+1], ext[j+2], ext[j+3]};
    end
    need       = {1'b0, round_idx, 2'b00} + 7'd4;
    gen        = (wcnt < need);
    last_round = (round_idx == 4'(NR));
  end

  aes_round_comb u_round (
    .state_in  (st),
    .rkey      (rkey),
    .last      (last_round),
    .state_out (rnd_out)
  );

  // Control FSM, state register, key window and registered handshake outputs.
  always_ff @(posedge eph1) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      st        <= '0;
      wcnt      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_block <= '0;
      busy      <= 1'b0;
      round_idx <= '0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            st <= in_block ^ in_key[KEY_BITS-1 -: 128];
            for (int k = 0; k < NK; k++) win[k] <= in_key[KEY_BITS-1-32*k -: 32];
            wcnt      <= 7'(NK);
            round_idx <= 4'd1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          st <= rnd_out;
          if (gen) begin
            wcnt <= wcnt + 7'd4;
            for (int k = 0; k < NK; k++) win[k] <= ext[k+4];
          end
          if (last_round) begin
            out_block <= rnd_out;
            out_valid <= 1'b1;
            round_idx <= '0;
            fsm       <= ST_DONE;
          end else begin
            round_idx <= round_idx + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Parametrised iterative AES encryption core. It generalises the single-round datapath to a full AES-128/192/256 block cipher: one round per clock, with round keys expanded on the fly from the cipher key. Block and key are captured through a valid/ready handshake. The ciphertext is held on a valid/ready output until it is consumed. It sits between the block-feed logic and the ciphertext sink; the key is supplied per block, so consecutive blocks may use different keys.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128/192/256; any other value is an elaboration error.
NK, KEY_BITS/32, derived key words (4/6/8); not overridable.
NR, NK+6, derived round count (10/12/14); not overridable.

Ports:
eph1  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  block+key offered.
in_ready  out  1  core can accept.
in_block  in  128  plaintext; [127:120] is FIPS byte 0, column-major.
in_key  in  KEY_BITS  cipher key; [KEY_BITS-1 -: 8] is key byte 0.
out_valid  out  1  ciphertext available.
out_ready  in  1  sink accepts.
out_block  out  128  ciphertext, same byte order as in_block.
busy  out  1  high in ROUND or DONE.
round_idx  out  4  current round number (debug); 0 in IDLE.

Behaviour:
- Reset, sampled at posedge: state=IDLE, in_ready=1, out_valid=0, out_block=0, busy=0, round_idx=0. Reset mid-operation abandons the block; nothing is emitted.
- States: IDLE, ROUND, DONE.
- IDLE: in_ready=1. When in_valid&in_ready:
  - state <= in_block ^ key_words[0..3] (round-0 AddRoundKey).
  - Key window <= in_key (NK words w[0..NK-1]); word counter i <= NK.
  - round_idx <= 1; go to ROUND.
- ROUND: each cycle applies round round_idx. SubBytes, ShiftRows and MixColumns run in every round except the last, which skips MixColumns; then XOR with round key words w[4r..4r+3].
  - The round key comes from the key window; 4 new words are generated per cycle as needed.
  - Word rule: w[i] = w[i-1] ^ w[i-NK] when i mod NK != 0. When i mod NK == 0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/NK]. When NK==8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - For NK=6 the round-key boundary is unaligned to the window; the expander keeps a buffer of at least 4 unconsumed words.
  - round_idx increments; after round NR, out_block <= result, out_valid <= 1, go to DONE.
- Latency: accept edge to out_valid high = NR cycles (10/12/14).
- DONE: out_valid=1, out_block stable, in_ready=0.
  - out_valid&out_ready -> IDLE, out_valid <= 0.
  - The new block may be accepted on the cycle after the out handshake, not the same cycle.
  - Throughput: one block per NR+2 cycles with out_ready held high.
- in_ready is 0 in ROUND and DONE. in_valid asserted there is ignored, and in_block/in_key are not sampled.
- Sampled inputs are latched at accept; later changes to in_block/in_key have no effect on the block in flight.
- Rcon: 01,02,04,08,10,20,40,80,1b,36, by GF(2^8) doubling; max index used is 10 (NK=4), 8 (NK=6), 7 (NK=8).
- x2: left shift, XOR 8'h1b if bit7 was set. x3 = x2 ^ x.
- No X on outputs after reset; out_block holds its last value in IDLE.

Decomposition:
- aes_pkg holds:
  - the SBOX constant, indexed directly by byte value (SBOX[8'h00]=8'h63, no reversed indexing);
  - functions x2, x3, sub_word, rot_word and rcon;
  - typedefs aes_state_t ([15:0][7:0]) and aes_word_t ([31:0]);
  - the state enum.
- One sub-module, aes_round_comb, is purely combinational: state_in, rkey, last -> state_out (SubBytes/ShiftRows/MixColumns-bypass/AddRoundKey). The core instantiates it once.
- Key expansion stays inline in aes_iter_core, using the aes_pkg functions.

Test Plan:
- KEY_BITS=128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 cycles after accept.
- KEY_BITS=192: key 000102…1617, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191, 12 cycles.
- KEY_BITS=256: key 000102…1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, 14 cycles.
- Backpressure (128): out_ready=0 for 20 cycles after out_valid -> out_block stable, in_ready=0, extra in_valid ignored. Then out_ready=1 for one cycle -> out_valid=0 next cycle. The next block (key 000102…0f, pt 00112233…ff) yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reset mid-flight: assert reset at round 5 -> next cycle IDLE, out_valid=0, round_idx=0. A fresh FIPS vector afterwards is correct.
- Back-to-back streaming with out_ready=1 and random key changes: 1000 blocks checked against a reference model. Accepts are spaced exactly NR+2 cycles apart.
